// File: rtl/rv32_ifetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// rv32_ifetch : instruction fetch front end with one-entry tagged buffer,
//               req/ack memory port and timeout-to-NOP fault handling.
// Revision    : 1.0
// ============================================================================
module rv32_ifetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] pc,
  output logic [31:0] data_bus,
  output logic        busy,
  output logic        fetch_fault,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int unsigned        TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic               imem_req_q,  imem_req_d;
  logic [31:0]        imem_addr_q, imem_addr_d;
  logic               buf_valid_q, buf_valid_d;
  logic [31:0]        buf_tag_q,   buf_tag_d;
  logic [31:0]        buf_data_q,  buf_data_d;
  logic               fault_q,     fault_d;
  logic [TMO_W-1:0]   tmo_cnt_q,   tmo_cnt_d;

  logic               hit;
  logic               resp_for_pc;
  logic               ack_valid;
  logic               tmo_limit;

  assign hit         = buf_valid_q && (buf_tag_q == pc);
  // A response is only useful if the PC unit still wants that address.
  assign resp_for_pc = (imem_addr_q == pc);
  assign ack_valid   = imem_ack && imem_req_q;
  assign tmo_limit   = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    fault_d     = fault_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (enable && !hit) begin
          state_d     = S_WAIT;
          imem_req_d  = 1'b1;
          imem_addr_d = pc;
          tmo_cnt_d   = '0;
        end
      end

      S_WAIT: begin
        // Ack takes priority over the timeout in the same cycle.
        if (ack_valid) begin
          state_d    = S_IDLE;
          imem_req_d = 1'b0;
          if (resp_for_pc) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = imem_addr_q;
            buf_data_d  = imem_rdata;
          end
        end else if (tmo_limit) begin
          state_d    = S_IDLE;
          imem_req_d = 1'b0;
          fault_d    = 1'b1;
          if (resp_for_pc) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = imem_addr_q;
            buf_data_d  = NOP_WORD;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= NOP_WORD;
      fault_q     <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      fault_q     <= fault_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign data_bus    = buf_data_q;
  assign busy        = ~hit;
  assign fetch_fault = fault_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_ifetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_rv32_ifetch : scoreboard bench for rv32_ifetch with a latency-programmable
//                  instruction memory responder.
// Revision       : 1.0
// ============================================================================
module tb_rv32_ifetch;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] pc;
  logic [31:0] data_bus;
  logic        busy;
  logic        fetch_fault;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  always #5 clk = ~clk;

  rv32_ifetch #(
    .TIMEOUT_CYCLES(TMO),
    .NOP_WORD      (NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pc         (pc),
    .data_bus   (data_bus),
    .busy       (busy),
    .fetch_fault(fetch_fault),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  int          mem_lat;
  bit          ovr_en;
  logic [31:0] ovr_addr;
  logic [31:0] ovr_data;

  int          cur_req_len  = 0;
  int          last_req_len = 0;
  logic        prev_req     = 1'b0;
  logic [31:0] req_addr_lat = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h1:   return 32'h0010_0113;
      32'h2:   return 32'h0020_8193;
      32'h5:   return 32'h00C0_0293;
      32'h20:  return 32'h0000_0513;
      default: return 32'h1000_0000 ^ a;
    endcase
  endfunction

  // Memory responder: acks in the cycle mem_lat cycles after the request rose.
  initial begin : mem_model
    int age;
    age        = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (rst_n && imem_req) begin
        if (mem_lat >= 0 && age == mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = (ovr_en && imem_addr == ovr_addr) ? ovr_data : mem_word(imem_addr);
        end
        age++;
      end else begin
        age = 0;
      end
    end
  end

  // Request monitor: pops the expected address on each new request.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req    = 1'b0;
      cur_req_len = 0;
    end else begin
      if (imem_req) begin
        if (!prev_req) begin
          n_checks++;
          if (exp_addr_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_unexpected: request to addr=%h with empty scoreboard", imem_addr);
          end else begin
            logic [31:0] e;
            e = exp_addr_q.pop_front();
            if (imem_addr !== e) begin
              n_fail++;
              $display("FAIL req_addr: got %h expected %h", imem_addr, e);
            end
          end
          req_addr_lat = imem_addr;
          cur_req_len  = 1;
        end else begin
          cur_req_len++;
          n_checks++;
          if (imem_addr !== req_addr_lat) begin
            n_fail++;
            $display("FAIL req_addr_stable: got %h expected %h", imem_addr, req_addr_lat);
          end
        end
      end else if (prev_req) begin
        last_req_len = cur_req_len;
      end
      prev_req = imem_req;
    end
  end

  task automatic wait_not_busy(input int budget, output int cyc, output bit expired);
    cyc     = 0;
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        expired = 1'b0;
        break;
      end
      cyc++;
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int cyc; bit expired; logic [31:0] e;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", busy); end
    n_checks++;
    if (data_bus !== NOP) begin n_fail++; $display("FAIL rst_data: got %h expected %h", data_bus, NOP); end
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_req: got req=%b addr=%h expected req=0 addr=0", imem_req, imem_addr);
    end
    n_checks++;
    if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", fetch_fault); end

    @(posedge clk); #1;
    pc      = 32'h0;
    mem_lat = 0;
    enable  = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_data_q.push_back(32'h0050_0093);
    rst_n   = 1'b1;
    wait_not_busy(20, cyc, expired);
    n_checks++;
    if (expired || cyc != 2) begin
      n_fail++; $display("FAIL first_busy: got %0d cycles (expired=%0d) expected 2", cyc, expired);
    end
    e = exp_data_q.pop_front();
    n_checks++;
    if (data_bus !== e) begin n_fail++; $display("FAIL first_data: got %h expected %h", data_bus, e); end
    @(negedge clk);
    n_checks++;
    if (last_req_len != 1) begin n_fail++; $display("FAIL first_req_len: got %0d expected 1", last_req_len); end
  endtask

  task automatic test_sequential();
    int cyc; bit expired; logic [31:0] e;
    reset_dut();
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      mem_lat = 3;
      pc      = 32'(n);
      enable  = 1'b1;
      exp_addr_q.push_back(32'(n));
      exp_data_q.push_back(mem_word(32'(n)));
      wait_not_busy(30, cyc, expired);
      n_checks++;
      if (expired || cyc != 5) begin
        n_fail++; $display("FAIL seq_busy[%0d]: got %0d cycles (expired=%0d) expected 5", n, cyc, expired);
      end
      e = exp_data_q.pop_front();
      n_checks++;
      if (data_bus !== e) begin n_fail++; $display("FAIL seq_data[%0d]: got %h expected %h", n, data_bus, e); end
      @(negedge clk);
      n_checks++;
      if (last_req_len != 4) begin n_fail++; $display("FAIL seq_req_len[%0d]: got %0d expected 4", n, last_req_len); end
    end
  endtask

  task automatic test_hit();
    int cyc; bit expired; logic [31:0] e;
    @(posedge clk); #1;
    mem_lat = 0;
    pc      = 32'h5;
    enable  = 1'b1;
    exp_addr_q.push_back(32'h5);
    exp_data_q.push_back(mem_word(32'h5));
    wait_not_busy(20, cyc, expired);
    n_checks++;
    if (expired || cyc != 2) begin
      n_fail++; $display("FAIL hit_fill_busy: got %0d cycles (expired=%0d) expected 2", cyc, expired);
    end
    e = exp_data_q.pop_front();
    n_checks++;
    if (data_bus !== e) begin n_fail++; $display("FAIL hit_fill_data: got %h expected %h", data_bus, e); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      enable = ~enable;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL hit_hold[%0d]: got req=%b busy=%b expected req=0 busy=0", i, imem_req, busy);
      end
    end
  endtask

  task automatic test_stale();
    int cyc; bit expired; logic [31:0] e;
    @(posedge clk); #1;
    mem_lat  = 3;
    ovr_en   = 1'b1;
    ovr_addr = 32'h4;
    ovr_data = 32'hDEAD_BEEF;
    pc       = 32'h4;
    enable   = 1'b1;
    exp_addr_q.push_back(32'h4);
    @(posedge clk);
    @(posedge clk); #1;
    pc = 32'h20;
    exp_addr_q.push_back(32'h20);
    exp_data_q.push_back(mem_word(32'h20));
    wait_not_busy(40, cyc, expired);
    n_checks++;
    if (expired || cyc != 8) begin
      n_fail++; $display("FAIL stale_busy: got %0d cycles (expired=%0d) expected 8", cyc, expired);
    end
    e = exp_data_q.pop_front();
    n_checks++;
    if (data_bus !== e) begin n_fail++; $display("FAIL stale_data: got %h expected %h", data_bus, e); end
    @(negedge clk);
    n_checks++;
    if (last_req_len != 4) begin n_fail++; $display("FAIL stale_req_len: got %0d expected 4", last_req_len); end
    ovr_en = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc; bit expired; logic [31:0] e;
    @(posedge clk); #1;
    mem_lat = -1;
    pc      = 32'h7;
    enable  = 1'b1;
    exp_addr_q.push_back(32'h7);
    exp_data_q.push_back(NOP);
    @(negedge clk);
    n_checks++;
    if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL tmo_fault_pre: got %b expected 0", fetch_fault); end
    wait_not_busy(40, cyc, expired);
    n_checks++;
    if (expired || cyc != TMO) begin
      n_fail++; $display("FAIL tmo_busy: got %0d cycles after first (expired=%0d) expected %0d", cyc, expired, TMO);
    end
    e = exp_data_q.pop_front();
    n_checks++;
    if (data_bus !== e || fetch_fault !== 1'b1) begin
      n_fail++; $display("FAIL tmo_result: got data=%h fault=%b expected data=%h fault=1", data_bus, fetch_fault, e);
    end
    @(negedge clk);
    n_checks++;
    if (last_req_len != TMO) begin n_fail++; $display("FAIL tmo_req_len: got %0d expected %0d", last_req_len, TMO); end

    @(posedge clk); #1;
    mem_lat = 1;
    pc      = 32'h8;
    exp_addr_q.push_back(32'h8);
    exp_data_q.push_back(mem_word(32'h8));
    wait_not_busy(30, cyc, expired);
    e = exp_data_q.pop_front();
    n_checks++;
    if (expired || cyc != 3 || data_bus !== e || fetch_fault !== 1'b1) begin
      n_fail++; $display("FAIL tmo_sticky: got cyc=%0d data=%h fault=%b expected cyc=3 data=%h fault=1",
                         cyc, data_bus, fetch_fault, e);
    end
    reset_dut();
    @(negedge clk);
    n_checks++;
    if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL tmo_fault_clear: got %b expected 0", fetch_fault); end
  endtask

  task automatic test_reset_mid_request();
    @(posedge clk); #1;
    mem_lat = -1;
    pc      = 32'h9;
    enable  = 1'b1;
    exp_addr_q.push_back(32'h9);
    repeat (3) @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_pending: got req=%b expected 1", imem_req); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_async: got req=%b busy=%b expected req=0 busy=1", imem_req, busy);
    end
    @(posedge clk); #1;
    enable = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_ack_at_limit();
    int cyc; bit expired; logic [31:0] e;
    @(posedge clk); #1;
    mem_lat  = TMO - 1;
    ovr_en   = 1'b1;
    ovr_addr = 32'h40;
    ovr_data = 32'h00A0_0113;
    pc       = 32'h40;
    enable   = 1'b1;
    exp_addr_q.push_back(32'h40);
    exp_data_q.push_back(32'h00A0_0113);
    wait_not_busy(40, cyc, expired);
    n_checks++;
    if (expired || cyc != TMO + 1) begin
      n_fail++; $display("FAIL limit_busy: got %0d cycles (expired=%0d) expected %0d", cyc, expired, TMO + 1);
    end
    e = exp_data_q.pop_front();
    n_checks++;
    if (data_bus !== e || fetch_fault !== 1'b0) begin
      n_fail++; $display("FAIL limit_result: got data=%h fault=%b expected data=%h fault=0", data_bus, fetch_fault, e);
    end
    @(negedge clk);
    n_checks++;
    if (last_req_len != TMO) begin n_fail++; $display("FAIL limit_req_len: got %0d expected %0d", last_req_len, TMO); end
    ovr_en = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n    = 1'b0;
    enable   = 1'b0;
    pc       = 32'h0;
    mem_lat  = 0;
    ovr_en   = 1'b0;
    ovr_addr = '0;
    ovr_data = '0;

    test_reset();
    test_sequential();
    test_hit();
    test_stale();
    test_timeout();
    test_reset_mid_request();
    test_ack_at_limit();

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_addr_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending requests expected 0", exp_addr_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32_ifetch.md
# rv32_ifetch

Instruction-fetch front end between the RV32 program counter unit and instruction memory. Takes the word-addressed `pc` from the PC unit, issues a request/acknowledge read to instruction memory, and holds the fetched word in a one-entry, address-tagged buffer. It drives `data_bus` back to the PC unit and decode, and asserts `busy` so the PC unit stalls until the instruction for the current `pc` is present. A timeout counter substitutes a NOP and flags a fault when memory never answers.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of WAIT cycles without an ack before the request is abandoned. Range 1..65535.
- `NOP_WORD`, default 32'h0000_0013: word substituted on timeout (`addi x0,x0,0`).

- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: permits new memory requests. An outstanding request always completes.
- `pc` input 32: word address of the required instruction, from the PC unit.
- `data_bus` output 32: buffered instruction word. Valid when `busy`=0.
- `busy` output 1: combinational; 1 unless the buffer is valid and its tag equals `pc`.
- `fetch_fault` output 1: sticky; set on timeout, cleared only by reset.
- `imem_req` output 1: registered read request.
- `imem_addr` output 32: registered word address, stable while `imem_req`=1.
- `imem_ack` input 1: one-cycle acknowledge. Sampled only while in WAIT with `imem_req`=1.
- `imem_rdata` input 32: read data, valid in the `imem_ack` cycle.

## Operation
- State: FSM {IDLE, WAIT}, buffer `buf_valid`, `buf_tag[31:0]`, `buf_data[31:0]`, and a timeout counter `tmo_cnt` of width clog2(TIMEOUT_CYCLES+1).
- Hit: `buf_valid && buf_tag==pc`. `busy = ~hit`. `data_bus = buf_data`.
- IDLE, with `enable` and a miss: at the edge, go to WAIT, set `imem_req`=1, set `imem_addr`=`pc`, clear `tmo_cnt`.
- IDLE, on a hit or with `enable`=0: stay in IDLE. No request is issued.
- WAIT with `imem_ack`=1: at the edge, deassert `imem_req` and return to IDLE. Then:
  - If `imem_addr==pc`, load `buf_data`=`imem_rdata`, `buf_tag`=`imem_addr`, and `buf_valid`=1.
  - Otherwise the response is stale. Discard it and leave the buffer unchanged; IDLE re-requests on the next cycle.
- WAIT without ack: `tmo_cnt` increments. When `tmo_cnt==TIMEOUT_CYCLES-1` and there is no ack:
  - At the edge, deassert `imem_req`, set `fetch_fault`=1, and return to IDLE.
  - If `imem_addr==pc`, load `buf_data`=`NOP_WORD` with tag `imem_addr`.
- Ack in the same cycle as the timeout limit: the ack wins. Real data is loaded and `fetch_fault` is unchanged.
- A buffer load overwrites the previous entry. There is no separate invalidate path; a `pc` redirect is a tag miss.
- `enable` dropping in WAIT does not cancel the request.
- At most one request is outstanding. `imem_req` never rises in the cycle after it fell, because IDLE always intervenes.
- Widths: all address and data paths are 32-bit. Tags compare all 32 bits, with no alignment masking.

## Timing
- Reset values:
  - state IDLE, `imem_req`=0, `imem_addr`=0
  - `buf_valid`=0, `buf_tag`=0, `buf_data`=`NOP_WORD` (so `data_bus`=32'h0000_0013)
  - `fetch_fault`=0, `tmo_cnt`=0
  - `busy`=1, since the buffer is invalid
- Miss latency: `pc` changes at edge E0 → `imem_req` is high from E1 → ack arrives in the cycle starting at E1+L (L≥0) → buffer loads at E1+L+1 → `busy`=0 from E0+L+2. The minimum is 2 cycles, at L=0.
- Hit: `busy`=0 in the same cycle `pc` matches (combinational). No memory traffic.
- Timeout: `imem_req` is high for exactly TIMEOUT_CYCLES cycles. `busy` falls and `fetch_fault` rises at edge E1+TIMEOUT_CYCLES.
- Reset mid-request: `imem_req` drops asynchronously. Memory must ignore a pending ack once the request is withdrawn.

## Test plan
- Reset with `pc`=0 and a memory acking in the request cycle (L=0), mem[0]=32'h00500093 → `busy`=1 for 2 cycles, then `data_bus`=32'h00500093 and `busy`=0. `imem_req` is high for 1 cycle with `imem_addr`=0.
- Sequential `pc` 0→1→2 with L=3 → each step shows `busy`=1 for 5 cycles after the `pc` change. `imem_addr` is 0,1,2 in order, and `data_bus` matches mem[n].
- `pc` held at 5 with a valid buffer, `enable` toggled for 20 cycles → `imem_req` stays 0 and `busy` stays 0.
- Bench forces `pc` from 4 to 32'h20 while the request for 4 is in WAIT, with an ack of 32'hDEADBEEF for address 4 → word discarded and `busy` stays 1. A new request with `imem_addr`=32'h20 follows 1 cycle after the ack, then `data_bus`=mem[32'h20].
- TIMEOUT_CYCLES=8 with memory never acking → `imem_req` is high for exactly 8 cycles, then `data_bus`=32'h00000013, `busy`=0, `fetch_fault`=1. `fetch_fault` stays 1 through later normal fetches until `rst_n` is pulsed low.
- TIMEOUT_CYCLES=8 with the ack in the 8th WAIT cycle, rdata 32'h00A00113 → `data_bus`=32'h00A00113 and `fetch_fault`=0.
